// File: rtl/demux32_1_2_buf.sv
// 1-to-2 routing demultiplexer with a 2-entry buffer and a delivered-word
// counter per sink. Each incoming word is steered by in_sel and parked in
// its port's buffer, so a stalled sink never holds up the other one.

// Per-port buffer: 2-entry FIFO (head/tail registers + occupancy) and a
// wrapping delivery counter. head is the presented word; tail is kept at
// zero whenever it is vacant so head reads 0 once the buffer drains.
module demux32_1_2_buf_port #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic [CNT_W-1:0] cnt
);
  logic [WIDTH-1:0] head, tail;
  logic [1:0]       occ;
  logic             pop;

  assign valid = (occ != 2'd0);
  assign full  = (occ == 2'd2);
  assign data  = head;
  assign pop   = valid && pop_ready;

  // FIFO state and delivery counter; push is never asserted while full
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      occ  <= 2'd0;
      cnt  <= '0;
    end else begin
      if (pop) cnt <= cnt + 1'b1;
      case ({push, pop})
        2'b10: begin
          if (occ == 2'd0) head <= din;
          else             tail <= din;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          head <= tail;
          tail <= '0;
          occ  <= occ - 2'd1;
        end
        // push+pop only happens at occ=1: new word replaces the departing head
        2'b11: head <= din;
        default: ;
      endcase
    end
  end
endmodule

module demux32_1_2_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data,
  output logic             out2_valid,
  input  logic             out2_ready,
  output logic [WIDTH-1:0] out2_data,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]            sel_oh;
  logic [NUM_PORTS-1:0]            push;
  logic [NUM_PORTS-1:0]            full;
  logic [NUM_PORTS-1:0]            valid;
  logic [NUM_PORTS-1:0]            ready;
  logic [NUM_PORTS-1:0][WIDTH-1:0] data;
  logic [NUM_PORTS-1:0][CNT_W-1:0] cnt;

  // Ready depends only on registered occupancy of the selected port, never
  // on the sink readies, so a same-cycle pop does not free the slot early.
  assign in_ready = rst_n && !full[in_sel];
  assign sel_oh   = {in_sel, ~in_sel};
  assign push     = {NUM_PORTS{in_valid && in_ready}} & sel_oh;
  assign ready    = {out2_ready, out1_ready};

  genvar i;
  generate
    for (i = 0; i < NUM_PORTS; i++) begin : g_port
      demux32_1_2_buf_port #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_port (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push[i]),
        .din      (in_data),
        .pop_ready(ready[i]),
        .valid    (valid[i]),
        .data     (data[i]),
        .full     (full[i]),
        .cnt      (cnt[i])
      );
    end
  endgenerate

  assign out1_valid = valid[0];
  assign out1_data  = data[0];
  assign cnt1       = cnt[0];
  assign out2_valid = valid[1];
  assign out2_data  = data[1];
  assign cnt2       = cnt[1];
endmodule
